// File: rtl/contador_pkg.sv
// Shared types and default sizing for the cascaded mod-N digit counter.
package contador_pkg;

  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned DIGITOS_DEF = 4;
  localparam int unsigned MODULO_DEF  = 10;

  typedef logic [DIGIT_W-1:0] digit_t;

endpackage

// File: rtl/digito_modn.sv
// One modulo-N digit cell: load, step up/down with wrap, registered wrap pulse.
import contador_pkg::*;

module digito_modn #(
  parameter int unsigned MODULO = MODULO_DEF
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   step,
  input  logic   up_down,
  input  logic   load,
  input  digit_t load_digit,
  output digit_t digit,
  output logic   wrap,
  output logic   at_max_c,
  output logic   at_zero_c
);

  localparam int unsigned CMP_W = DIGIT_W + 1;
  localparam digit_t      MAX_D = DIGIT_W'(MODULO - 1);

  assign at_max_c  = (digit == MAX_D);
  assign at_zero_c = (digit == '0);

  // Out-of-range load nibbles collapse to zero so the digit never leaves 0..MODULO-1
  always_ff @(posedge clk) begin
    if (reset) begin
      digit <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      digit <= (CMP_W'(load_digit) >= CMP_W'(MODULO)) ? '0 : load_digit;
      wrap  <= 1'b0;
    end else if (step) begin
      if (up_down) begin
        digit <= at_max_c ? '0 : digit + DIGIT_W'(1);
        wrap  <= at_max_c;
      end else begin
        digit <= at_zero_c ? MAX_D : digit - DIGIT_W'(1);
        wrap  <= at_zero_c;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/contador_cascata_n.sv
// Cascaded DIGITOS-digit modulo-MODULO up/down counter with per-digit and global wrap pulses.
import contador_pkg::*;

module contador_cascata_n #(
  parameter int unsigned DIGITOS = DIGITOS_DEF,
  parameter int unsigned MODULO  = MODULO_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       up_down,
  input  logic                       load,
  input  logic [DIGIT_W*DIGITOS-1:0] load_value,
  output logic [DIGIT_W*DIGITOS-1:0] valor,
  output logic [DIGITOS-1:0]         carry_digito,
  output logic                       carry
);

  logic [DIGITOS:0]   step_chain;
  logic [DIGITOS-1:0] at_max;
  logic [DIGITOS-1:0] at_zero;

  assign step_chain[0] = enable;

  // Digit i steps only when every lower digit is at its wrap point in the current direction
  for (genvar i = 0; i < DIGITOS; i++) begin : g_dig
    digit_t d;

    digito_modn #(.MODULO(MODULO)) u_dig (
      .clk        (clk),
      .reset      (reset),
      .step       (step_chain[i]),
      .up_down    (up_down),
      .load       (load),
      .load_digit (load_value[DIGIT_W*i +: DIGIT_W]),
      .digit      (d),
      .wrap       (carry_digito[i]),
      .at_max_c   (at_max[i]),
      .at_zero_c  (at_zero[i])
    );

    assign valor[DIGIT_W*i +: DIGIT_W] = d;
    assign step_chain[i+1] = step_chain[i] & (up_down ? at_max[i] : at_zero[i]);
  end

  // Whole-counter wrap: the step ripples out past the top digit
  always_ff @(posedge clk) begin
    if (reset || load) begin
      carry <= 1'b0;
    end else begin
      carry <= step_chain[DIGITOS];
    end
  end

endmodule

// File: doc/contador_cascata_n.md
CONTADOR_CASCATA_N -- requirements
Module: contador_cascata_n

Interface
REQ-001 The block SHALL have parameter DIGITOS, default 4, number of cascaded digits (1..8).
REQ-002 The block SHALL have parameter MODULO, default 10, per-digit modulus (2..16).
REQ-003 The block SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port enable  input  1  count-step request for the current cycle.
REQ-006 The block SHALL have port up_down  input  1  count direction, 1 = up, 0 = down.
REQ-007 The block SHALL have port load  input  1  synchronous parallel load request.
REQ-008 The block SHALL have port load_value  input  4*DIGITOS  packed digits, digit 0 in bits [3:0].
REQ-009 The block SHALL have port valor  output  4*DIGITOS  registered count, digit 0 in bits [3:0].
REQ-010 The block SHALL have port carry_digito  output  DIGITOS  registered per-digit wrap pulse.
REQ-011 The block SHALL have port carry  output  1  registered whole-counter wrap pulse (carry when up, borrow when down).

Function
REQ-012 Priority per edge SHALL be: reset > load > enable > hold.
REQ-013 On load, each digit SHALL take its load_value nibble, and any nibble >= MODULO SHALL be replaced by 0.
REQ-014 On a load cycle, carry and all carry_digito bits SHALL be 0.
REQ-015 Up, enable=1: digit 0 SHALL increment, and digit i>0 SHALL increment only when every lower digit equals MODULO-1.
REQ-016 Up: a digit at MODULO-1 that steps SHALL become 0, and its carry_digito bit SHALL be 1 for that one cycle.
REQ-017 Down, enable=1: digit 0 SHALL decrement, and digit i>0 SHALL decrement only when every lower digit equals 0.
REQ-018 Down: a digit at 0 that steps SHALL become MODULO-1, and its carry_digito bit SHALL be 1 for that one cycle.
REQ-019 carry SHALL be 1 in exactly the cycle after the edge where valor wraps all-max -> all-zero (up) or all-zero -> all-max (down), i.e. carry SHALL equal carry_digito[DIGITOS-1].
REQ-020 Pulses SHALL be registered alongside valor; zero combinational latency from enable to outputs, one-edge latency overall.
REQ-021 With enable=0 and load=0, valor SHALL hold, and carry and carry_digito SHALL be 0.
REQ-022 A change of up_down between enabled cycles SHALL take effect on the next edge with no lost or extra step.
REQ-023 Digit values SHALL never leave 0..MODULO-1 after reset or load, and the unused nibble range SHALL be unreachable.
REQ-024 Continuous enable, up: valor SHALL cycle through MODULO^DIGITOS states, with one carry pulse per full cycle.

Reset
REQ-025 With reset=1 at an edge, valor SHALL be 0, carry SHALL be 0, and carry_digito SHALL be 0, regardless of load and enable.
REQ-026 Reset asserted mid-count SHALL take effect at the next edge with no pulse emitted for the aborted step.
REQ-027 Before the first reset edge, outputs SHALL be undefined, and the bench SHALL not check them.

Structure
REQ-028 Package contador_pkg SHALL hold the digit typedef (4-bit) and the default DIGITOS/MODULO constants.
REQ-029 The per-digit logic SHALL be sub-module digito_modn: inputs clk, reset, step, up_down, load, load digit; outputs digit, wrap flag, at-max, at-zero.
REQ-030 The top SHALL instantiate DIGITOS digito_modn cells in a generate loop, with step chaining from at-max/at-zero of lower digits.

Verification
REQ-031 DIGITOS=2, MODULO=10, reset then enable=1 up for 100 cycles -> valor 00..99 then 00, carry=1 only in the cycle valor=00 after 99, carry_digito[0]=1 every 10 steps.
REQ-032 DIGITOS=2, MODULO=10, from 00, one enabled down step -> valor=99, carry=1, carry_digito=2'b11; next down step -> 98, carry=0.
REQ-033 load=1, load_value=8'h57 -> valor=57, carry=0; then up step -> 58; load_value=8'hA3 -> valor=03.
REQ-034 At valor=42, enable=0 for 5 cycles -> valor=42 held, carry=0; reset=1 with load=1 and enable=1 -> valor=00, carry=0.
REQ-035 DIGITOS=2, MODULO=6, load 8'h55, up step -> valor=00, carry=1; down step -> valor=55, carry=1.
REQ-036 DIGITOS=3, MODULO=10, at 199, alternate up_down each enabled cycle -> 200, 199, 200, with carry_digito[1] pulsing each transition and carry=0.
